// File: rtl/memarb_pkg.sv
// memarb_pkg: shared types for the unified memory port arbiter.
//   state_t    - arbiter FSM states
//   port_idx_t - requester index (0 = CPU datapath, 1 = debug/program loader)
//   CNT_W      - width of the read-latency counter (RD_LAT up to 7)
package memarb_pkg;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef logic port_idx_t;

  // Index of the granted port from a one-hot (or zero) winner vector.
  function automatic port_idx_t onehot_to_idx(input logic [1:0] oh);
    return port_idx_t'(oh[1]);
  endfunction

endpackage

// File: rtl/memarb_pick.sv
// memarb_pick: winner selection for the two-port memory arbiter.
// Ports:
//   req      in  2  request vector {m1_req, m0_req}
//   ptr      in  1  round-robin pointer: port preferred on a conflict (RR build only)
//   next_ptr out 1  pointer value after this winner is issued (RR build only)
//   win      out 2  one-hot winner, zero when nothing is requested
// Build option: MEMARB_FIXED_PRIO_EN selects fixed priority (port 1 wins every
// conflict) and removes the pointer ports entirely.
module memarb_pick
  import memarb_pkg::*;
(
  input  logic [1:0] req,
`ifndef MEMARB_FIXED_PRIO_EN
  input  port_idx_t  ptr,
  output port_idx_t  next_ptr,
`endif
  output logic [1:0] win
);

`ifdef MEMARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    if (req[1])      win = 2'b10;
    else if (req[0]) win = 2'b01;
  end
`else
  always_comb begin
    win = req;
    // Only a true conflict consults the pointer; a lone requester always wins.
    if (req == 2'b11) win = ptr ? 2'b10 : 2'b01;
  end

  // After issue the pointer moves to the port that did not win.
  assign next_ptr = port_idx_t'(~win[1]);
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified instruction/data memory port between
// the multicycle CPU datapath (port 0) and the debug/program loader (port 1).
// A command is arbitrated in IDLE, registered and driven to memory for one
// ISSUE cycle; reads wait RD_LAT cycles and return data with a per-port
// rvalid pulse in RESP. All outputs are registered.
// Parameters: AW address width, DW data width, RD_LAT read latency (1..7).
// Ports:
//   clk, reset                      clock, async active-high reset
//   mX_req/we/addr/wdata   in       requester command (held until mX_gnt)
//   mX_gnt                 out      command accepted (1-cycle pulse)
//   mX_rvalid/mX_rdata     out      read data and its valid pulse
//   mem_addr/wdata/we/re   out      memory command
//   mem_rdata              in       memory read data
// Build option: MEMARB_FIXED_PRIO_EN -> port 1 always wins a conflict,
// no round-robin pointer.
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  port_idx_t        win_q;
  logic [DW-1:0]    rdata_q;

  logic [1:0]       req;
  logic [1:0]       win;
  port_idx_t        win_idx;
  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;

`ifndef MEMARB_FIXED_PRIO_EN
  port_idx_t        ptr;
  port_idx_t        ptr_next;
  port_idx_t        ptr_pend;
`endif

  assign req = {m1_req, m0_req};

  memarb_pick u_pick (
    .req      (req),
`ifndef MEMARB_FIXED_PRIO_EN
    .ptr      (ptr),
    .next_ptr (ptr_next),
`endif
    .win      (win)
  );

  assign win_idx = onehot_to_idx(win);

  always_comb begin
    cmd_we    = m0_we;
    cmd_addr  = m0_addr;
    cmd_wdata = m0_wdata;
    if (win_idx) begin
      cmd_we    = m1_we;
      cmd_addr  = m1_addr;
      cmd_wdata = m1_wdata;
    end
  end

  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      win_q     <= 1'b0;
      rdata_q   <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifndef MEMARB_FIXED_PRIO_EN
      ptr       <= 1'b0;
      ptr_pend  <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;

      case (state)
        IDLE: begin
          if (|req) begin
            // Outputs for the ISSUE cycle are loaded here so they are registered.
            win_q     <= win_idx;
            mem_we    <= cmd_we;
            mem_re    <= ~cmd_we;
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_wdata;
            m0_gnt    <= win[0];
            m1_gnt    <= win[1];
`ifndef MEMARB_FIXED_PRIO_EN
            // Requests may change after IDLE, so the pick result is held
            // until the pointer commits in ISSUE.
            ptr_pend  <= ptr_next;
`endif
            state     <= ISSUE;
          end
        end

        ISSUE: begin
`ifndef MEMARB_FIXED_PRIO_EN
          ptr <= ptr_pend;
`endif
          if (mem_we) begin
            state <= IDLE;
          end else begin
            cnt   <= LAT_LOAD;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == '0) begin
            rdata_q   <= mem_rdata;
            m0_rvalid <= ~win_q;
            m1_rvalid <= win_q;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;

  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;

  // DUT with RD_LAT=1
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, mem_re;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  // DUT with RD_LAT=4
  logic        q_m0_gnt, q_m0_rvalid, q_m1_gnt, q_m1_rvalid, q_mem_we, q_mem_re;
  logic [31:0] q_m0_rdata, q_m1_rdata, q_mem_addr, q_mem_wdata, q_mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(q_m0_gnt), .m0_rvalid(q_m0_rvalid), .m0_rdata(q_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(q_m1_gnt), .m1_rvalid(q_m1_rvalid), .m1_rdata(q_m1_rdata),
    .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_we(q_mem_we), .mem_re(q_mem_re),
    .mem_rdata(q_mem_rdata)
  );

  // Memory models: word array, read data registered RD_LAT cycles after ISSUE.
  logic [31:0] mem1 [64];
  logic [31:0] mem4 [64];
  logic [31:0] rd1;
  logic [31:0] p4 [4];

  always @(posedge clk) begin
    if (mem_init) begin
      mem1[4] <= 32'hDEADBEEF;
      mem1[8] <= 32'h12345678;
      mem4[4] <= 32'hDEADBEEF;
      mem4[8] <= 32'h12345678;
    end else begin
      if (mem_we)   mem1[mem_addr[7:2]]   <= mem_wdata;
      if (q_mem_we) mem4[q_mem_addr[7:2]] <= q_mem_wdata;
    end
    rd1   <= mem1[mem_addr[7:2]];
    p4[0] <= mem4[q_mem_addr[7:2]];
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end

  assign mem_rdata   = rd1;
  assign q_mem_rdata = p4[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated transaction on the RD_LAT=1 DUT, observed for 8 cycles.
  task automatic run_txn(input string tag, input int port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata);
    int gnt_cyc = 0, rv_cyc = 0, we_cnt = 0, re_cnt = 0, other = 0;
    logic [31:0] a_at = '0, wd_at = '0, rd_at = '0;
    logic [1:0]  strobe_at = '0;
    logic own_g, own_rv, oth;
    @(negedge clk);
    set_req(port, 1'b1, we, addr, wdata);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      own_g  = (port == 0) ? m0_gnt : m1_gnt;
      own_rv = (port == 0) ? m0_rvalid : m1_rvalid;
      oth    = (port == 0) ? (m1_gnt | m1_rvalid) : (m0_gnt | m0_rvalid);
      if (own_g && gnt_cyc == 0) begin
        gnt_cyc   = k;
        a_at      = mem_addr;
        wd_at     = mem_wdata;
        strobe_at = {mem_we, mem_re};
        set_req(port, 1'b0, 1'b0, '0, '0);
      end
      if (own_rv && rv_cyc == 0) begin
        rv_cyc = k;
        rd_at  = (port == 0) ? m0_rdata : m1_rdata;
      end
      we_cnt += int'(mem_we);
      re_cnt += int'(mem_re);
      other  += int'(oth);
    end
    set_req(port, 1'b0, 1'b0, '0, '0);
    check({tag, "_gnt_cycle"}, gnt_cyc, 1);
    check({tag, "_addr"}, a_at, addr);
    check({tag, "_strobe"}, {30'd0, strobe_at}, we ? 32'd2 : 32'd1);
    check({tag, "_we_cycles"}, we_cnt, we ? 1 : 0);
    check({tag, "_re_cycles"}, re_cnt, we ? 0 : 1);
    check({tag, "_rvalid_cycle"}, rv_cyc, we ? 0 : 3);
    check({tag, "_other_port"}, other, 0);
    if (we) check({tag, "_wdata"}, wd_at, wdata);
    else    check({tag, "_rdata"}, rd_at, rdata);
  endtask

  typedef struct {
    string       tag;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int order [8];
    int ng, n0, both, exp_first;
    int rv_cnt, g1_cyc, rv0_cyc;
    logic [31:0] rd_at;
    int gc, rec, rc, rvc;
    logic re_at;

    vecs[0] = '{"rd0_10", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{"wr1_40", 1, 1'b1, 32'h40, 32'hCAFE0001, 32'h0};
    vecs[2] = '{"rd0_40", 0, 1'b0, 32'h40, 32'h0, 32'hCAFE0001};
    vecs[3] = '{"rd1_10", 1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
    vecs[4] = '{"wr0_44", 0, 1'b1, 32'h44, 32'h0BADF00D, 32'h0};
    vecs[5] = '{"rd1_44", 1, 1'b0, 32'h44, 32'h0, 32'h0BADF00D};

    // Reset state
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    check("rst_ctrl", {26'd0, m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, mem_re}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata", m0_rdata, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ctrl", {26'd0, m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, mem_re}, 32'd0);

    // Table of isolated transactions
    foreach (vecs[i])
      run_txn(vecs[i].tag, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);

    // Both ports requesting continuously
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h10, '0);
    set_req(1, 1'b1, 1'b0, 32'h40, '0);
    ng = 0; n0 = 0; both = 0;
    for (int c = 0; c < 60 && ng < 8; c++) begin
      @(negedge clk);
      if (m0_gnt && m1_gnt) both++;
      if (m0_gnt) begin order[ng] = 0; ng++; n0++; end
      else if (m1_gnt) begin order[ng] = 1; ng++; end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    check("rr_grant_count", ng, 8);
    check("rr_double_grant", both, 0);
    for (int i = 0; i < ng; i++) begin
`ifdef MEMARB_FIXED_PRIO_EN
      check($sformatf("rr_order_%0d", i), order[i], 1);
`else
      check($sformatf("rr_order_%0d", i), order[i], i % 2);
`endif
    end
`ifdef MEMARB_FIXED_PRIO_EN
    check("rr_port0_share", n0, 0);
`else
    check("rr_port0_share", n0, 4);
`endif
    repeat (8) @(negedge clk);

    // One-cycle request pulse, then a request raised during WAIT
    set_req(0, 1'b1, 1'b0, 32'h10, '0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    check("pulse_gnt", {31'd0, m0_gnt}, 32'd1);
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 32'h48, 32'h55AA55AA);
    g1_cyc = 0; rv0_cyc = 0; rd_at = '0;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      if (m0_rvalid && rv0_cyc == 0) begin rv0_cyc = k; rd_at = m0_rdata; end
      if (m1_gnt && g1_cyc == 0) begin g1_cyc = k; set_req(1, 1'b0, 1'b0, '0, '0); end
    end
    set_req(1, 1'b0, 1'b0, '0, '0);
    check("pulse_rvalid_cycle", rv0_cyc, 3);
    check("pulse_rdata", rd_at, 32'hDEADBEEF);
    check("wait_req_gnt_cycle", g1_cyc, 5);
    repeat (4) @(negedge clk);

    // Reset asserted while a read is in WAIT
    set_req(0, 1'b1, 1'b0, 32'h10, '0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("pre_rst_addr", mem_addr, 32'h10);
    reset = 1'b1;
    #1;
    check("async_rst_ctrl", {26'd0, m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, mem_re}, 32'd0);
    check("async_rst_addr", mem_addr, 32'd0);
    check("async_rst_rdata", m0_rdata, 32'd0);
    check("async_rst_addr_lat4", q_mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rv_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rv_cnt += int'(m0_rvalid | m1_rvalid | q_m0_rvalid | q_m1_rvalid);
    end
    check("no_rvalid_after_rst", rv_cnt, 0);
    run_txn("post_rst_rd0", 0, 1'b0, 32'h10, '0, 32'hDEADBEEF);

    // RD_LAT=4 read on the second instance
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h20, '0);
    gc = 0; rc = 0; rec = 0; rvc = 0; re_at = 1'b0; rd_at = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (q_m0_gnt && gc == 0) begin gc = k; re_at = q_mem_re; set_req(0, 1'b0, 1'b0, '0, '0); end
      if (q_m0_rvalid && rc == 0) begin rc = k; rd_at = q_m0_rdata; end
      rec += int'(q_mem_re);
      rvc += int'(q_m0_rvalid);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    check("lat4_gnt_cycle", gc, 1);
    check("lat4_re_at_issue", {31'd0, re_at}, 32'd1);
    check("lat4_re_cycles", rec, 1);
    check("lat4_rvalid_cycle", rc, 6);
    check("lat4_rvalid_pulses", rvc, 1);
    check("lat4_rdata", rd_at, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
